// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer that owns the ProgramCounter and strobes the IR and datapath.
// Optional return stack enabled by defining SEQ_CALL_STACK_EN.
module pc_sequencer #(
  parameter int unsigned ADDR_W = 6
`ifdef SEQ_CALL_STACK_EN
  , parameter int unsigned STACK_DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              halt_req_i,
  input  logic              br_req_i,
  input  logic [ADDR_W-1:0] br_target_i,
`ifdef SEQ_CALL_STACK_EN
  input  logic              call_req_i,
  input  logic              ret_req_i,
  output logic              stk_err_o,
`endif
  output logic              pc_rst_o,
  output logic              pc_branch_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              ir_load_o,
  output logic              exec_en_o,
  output logic              busy_o,
  output logic              halted_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   seq_pc_q, seq_pc_d;

  logic                pc_rst_d, pc_branch_d, ir_load_d, exec_en_d, busy_d, halted_d;
  logic [ADDR_W-1:0]   pc_target_d;
  logic                pc_rst_q, pc_branch_q, ir_load_q, exec_en_q, busy_q, halted_q;
  logic [ADDR_W-1:0]   pc_target_q;

`ifdef SEQ_CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]   stk_q [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q;
  logic                stk_err_q, stk_err_d;
  logic                stk_push, stk_pop, stk_fault;
`endif

  // State, address, output and stack registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seq_pc_q    <= '0;
      pc_rst_q    <= 1'b1;
      pc_branch_q <= 1'b0;
      pc_target_q <= '0;
      ir_load_q   <= 1'b0;
      exec_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
`ifdef SEQ_CALL_STACK_EN
      sp_q        <= '0;
      stk_err_q   <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      seq_pc_q    <= seq_pc_d;
      pc_rst_q    <= pc_rst_d;
      pc_branch_q <= pc_branch_d;
      pc_target_q <= pc_target_d;
      ir_load_q   <= ir_load_d;
      exec_en_q   <= exec_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
`ifdef SEQ_CALL_STACK_EN
      stk_err_q   <= stk_err_d;
      if (stk_push) begin
        stk_q[IDX_W'(sp_q)] <= seq_pc_q + ADDR_W'(1);
        sp_q                <= sp_q + SP_W'(1);
      end else if (stk_pop) begin
        sp_q                <= sp_q - SP_W'(1);
      end
`endif
    end
  end

  // Next state and next fetch address; halt beats stall beats normal progress
  always_comb begin
    state_d  = state_q;
    seq_pc_d = seq_pc_q;
`ifdef SEQ_CALL_STACK_EN
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_fault = 1'b0;
    stk_err_d = stk_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH, S_DECODE, S_EXEC: begin
        if (halt_req_i) begin
          state_d = S_HALT;
        end else if (!stall_i) begin
          unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            default: begin
`ifdef SEQ_CALL_STACK_EN
              if (ret_req_i) begin
                if (sp_q == '0) begin
                  stk_fault = 1'b1;
                  state_d   = S_HALT;
                end else begin
                  stk_pop  = 1'b1;
                  seq_pc_d = stk_q[IDX_W'(sp_q - SP_W'(1))];
                  state_d  = S_FETCH;
                end
              end else if (call_req_i) begin
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                  stk_fault = 1'b1;
                  state_d   = S_HALT;
                end else begin
                  stk_push = 1'b1;
                  seq_pc_d = br_target_i;
                  state_d  = S_FETCH;
                end
              end else
`endif
              begin
                seq_pc_d = br_req_i ? br_target_i : seq_pc_q + ADDR_W'(1);
                state_d  = S_FETCH;
              end
            end
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
`ifdef SEQ_CALL_STACK_EN
    if (stk_fault) stk_err_d = 1'b1;
`endif
  end

  // Output values for the coming cycle; strobes mark a FETCH or EXEC that completed
  always_comb begin
    pc_rst_d    = 1'b0;
    pc_branch_d = 1'b0;
    pc_target_d = '0;
    ir_load_d   = 1'b0;
    exec_en_d   = 1'b0;
    busy_d      = 1'b0;
    halted_d    = 1'b0;
    if (state_d == S_IDLE) begin
      pc_rst_d = 1'b1;
    end else begin
      pc_branch_d = 1'b1;
      pc_target_d = seq_pc_d;
    end
    busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    halted_d  = (state_d == S_HALT);
    ir_load_d = (state_q == S_FETCH) && (state_d == S_DECODE);
    exec_en_d = (state_q == S_EXEC) && (state_d == S_FETCH);
  end

  assign pc_rst_o    = pc_rst_q;
  assign pc_branch_o = pc_branch_q;
  assign pc_target_o = pc_target_q;
  assign ir_load_o   = ir_load_q;
  assign exec_en_o   = exec_en_q;
  assign busy_o      = busy_q;
  assign halted_o    = halted_q;
`ifdef SEQ_CALL_STACK_EN
  assign stk_err_o   = stk_err_q;
`endif

endmodule
